bank_cmd_arbiter: RTL and testbench
===================================

BANK_CMD_ARBITER -- requirements
Module: bank_cmd_arbiter

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 8, number of bank_FSM requesters sharing the DRAM command bus.
REQ-002 SHALL have parameter T_RRD, default 4, minimum cycles between two ACT issues.
REQ-003 SHALL have parameter T_CCD, default 4, minimum cycles between two RD/WR issues.
REQ-004 SHALL have parameter T_WTR, default 6, minimum cycles from a WR issue to the next RD issue.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_i  input  NUM_BANKS  per-bank issue request (bank ba_issue).
REQ-008 SHALL have port req_cmd_i  input  NUM_BANKS x 3  per-bank command code (arb_cmd_t).
REQ-009 SHALL have port req_addr_i  input  NUM_BANKS x `ADDR_BITS  per-bank row/column address (bank ba_addr).
REQ-010 SHALL have port cmd_ready_i  input  1  PHY command slot available this cycle.
REQ-011 SHALL have port grant_o  output  NUM_BANKS  one-hot grant, combinational.
REQ-012 SHALL have port stall_o  output  NUM_BANKS  per-bank stall, drives bank stall input.
REQ-013 SHALL have port cmd_valid_o / cmd_type_o / cmd_bank_o / cmd_addr_o  output  1 / 3 / 3 / `ADDR_BITS  registered command to PHY.

Function
REQ-014 SHALL grant at most one bank per cycle; grant_o SHALL be zero when cmd_ready_i=0.
REQ-015 SHALL set stall_o[i] = req_i[i] & ~grant_o[i] every cycle.
REQ-016 Eligibility: ACT only if rrd_cnt=0; RD only if ccd_cnt=0 and wtr_cnt=0; WR only if ccd_cnt=0; PRE, PREA, REF always; NOP never (no grant, no stall).
REQ-017 Priority: eligible REF/PREA requests SHALL beat all others; within the winning class, round-robin starting at rr_ptr.
REQ-018 After a grant to bank g, rr_ptr SHALL become (g+1) mod NUM_BANKS; with no grant rr_ptr SHALL hold.
REQ-019 Granted command SHALL appear on cmd_*_o exactly one cycle after grant, cmd_valid_o=1 for one cycle; cmd_bank_o = g.
REQ-020 With no grant, cmd_valid_o SHALL be 0 next cycle and cmd_type_o SHALL be NOP; cmd_addr_o/cmd_bank_o hold.
REQ-021 On ACT grant rrd_cnt SHALL load T_RRD-1; on RD/WR grant ccd_cnt SHALL load T_CCD-1; on WR grant wtr_cnt SHALL load T_WTR-1.
REQ-022 Counters SHALL decrement by one per cycle when nonzero, saturate at 0, and keep decrementing while cmd_ready_i=0.
REQ-023 Counter widths SHALL be $clog2(max(T)+1); a parameter of 1 SHALL impose no spacing.
REQ-024 Requests from an ineligible bank SHALL remain stalled, never dropped, until granted.
REQ-025 All-requesting, all-eligible banks SHALL each be granted within NUM_BANKS grant cycles (no starvation within class).

Reset
REQ-026 On rst_n=0: grant_o=0, stall_o=0, cmd_valid_o=0, cmd_type_o=NOP, cmd_bank_o=0, cmd_addr_o=0, rr_ptr=0, all counters 0.
REQ-027 Reset mid-operation SHALL discard any pending registered command; first grant after release SHALL start at bank 0.

Structure
REQ-028 arb_cmd_t (NOP, ACT, RD, WR, PRE, PREA, REF) SHALL live in the shared usertype package; T_* defaults in define.sv.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in, one-hot grant out), instanced twice (priority class, normal class).

Verification
REQ-030 Banks 0,3 request ACT same cycle, rr_ptr=0 -> bank 0 granted, bank 3 stalled T_RRD-1=3 cycles, granted 4 cycles after bank 0.
REQ-031 Bank 2 WR, bank 5 RD next cycle -> RD issued 6 cycles after WR (T_WTR), stall_o[5]=1 during gap.
REQ-032 Bank 1 RD and bank 6 REF same cycle, rr_ptr=1 -> bank 6 granted first, cmd_type_o=REF next cycle.
REQ-033 All 8 banks request PRE, cmd_ready_i=1 -> grants 0..7 in consecutive cycles, 8 cmd_valid_o pulses.
REQ-034 cmd_ready_i=0 for 3 cycles with bank 4 ACT pending -> no grant, stall_o[4]=1; grant in first cycle cmd_ready_i=1.
REQ-035 rst_n asserted cycle after grant -> cmd_valid_o=0 immediately, rr_ptr=0, counters 0 after release.

Source files
------------

// File: rtl/bank_cmd_arbiter_pkg.sv
// Shared types and timing defaults for the bank command arbiter.
package bank_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } arb_cmd_t;

  localparam int ADDR_BITS     = 16;
  localparam int T_RRD_DEFAULT = 4;
  localparam int T_CCD_DEFAULT = 4;
  localparam int T_WTR_DEFAULT = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Refresh and precharge-all must never be held off by ordinary traffic.
  function automatic logic is_prio_cmd(input arb_cmd_t c);
    return (c == CMD_REF) || (c == CMD_PREA);
  endfunction

endpackage

// File: rtl/bank_cmd_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr_i, wrapping to bank 0.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic w_found;

  always_comb begin
    grant_o = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req_i[i] && (i >= int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && req_i[i] && (i < int'(ptr_i))) begin
        grant_o[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_cmd_arbiter.sv
// Shared DRAM command-bus arbiter: one bank per cycle, honouring tRRD/tCCD/tWTR,
// with REF/PREA ahead of all other commands and round-robin within each class.
module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
#(
  parameter int  NUM_BANKS = 8,
  parameter int  T_RRD     = T_RRD_DEFAULT,
  parameter int  T_CCD     = T_CCD_DEFAULT,
  parameter int  T_WTR     = T_WTR_DEFAULT,
  localparam int BANK_W    = bank_w(NUM_BANKS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_BANKS-1:0]                req_i,
  input  logic [NUM_BANKS-1:0][2:0]           req_cmd_i,
  input  logic [NUM_BANKS-1:0][ADDR_BITS-1:0] req_addr_i,
  input  logic                                cmd_ready_i,
  output logic [NUM_BANKS-1:0]                grant_o,
  output logic [NUM_BANKS-1:0]                stall_o,
  output logic                                cmd_valid_o,
  output logic [2:0]                          cmd_type_o,
  output logic [BANK_W-1:0]                   cmd_bank_o,
  output logic [ADDR_BITS-1:0]                cmd_addr_o
);

  localparam int CNT_W = $clog2(max3(T_RRD, T_CCD, T_WTR) + 1);
  localparam logic [CNT_W-1:0] RRD_LOAD = CNT_W'(T_RRD - 1);
  localparam logic [CNT_W-1:0] CCD_LOAD = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] WTR_LOAD = CNT_W'(T_WTR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [BANK_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]     r_rrd_cnt;
  logic [CNT_W-1:0]     r_ccd_cnt;
  logic [CNT_W-1:0]     r_wtr_cnt;
  logic                 r_cmd_valid;
  arb_cmd_t             r_cmd_type;
  logic [BANK_W-1:0]    r_cmd_bank;
  logic [ADDR_BITS-1:0] r_cmd_addr;

  logic                 w_act_ok;
  logic                 w_rd_ok;
  logic                 w_wr_ok;
  logic [NUM_BANKS-1:0] w_prio_req;
  logic [NUM_BANKS-1:0] w_norm_req;
  logic [NUM_BANKS-1:0] w_live;
  logic [NUM_BANKS-1:0] w_prio_gnt;
  logic [NUM_BANKS-1:0] w_norm_gnt;
  logic [NUM_BANKS-1:0] w_grant;
  logic                 w_any_gnt;
  logic [BANK_W-1:0]    w_gnt_idx;
  arb_cmd_t             w_gnt_cmd;
  logic [ADDR_BITS-1:0] w_gnt_addr;
  logic [BANK_W-1:0]    w_ptr_next;

  assign w_act_ok = (r_rrd_cnt == '0);
  assign w_rd_ok  = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
  assign w_wr_ok  = (r_ccd_cnt == '0);

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    arb_cmd_t w_cmd;
    logic     w_ok;
    logic     w_known;

    assign w_cmd = arb_cmd_t'(req_cmd_i[gi]);

    // NOP and undefined codes are not real requests: never granted, never stalled.
    always_comb begin
      w_ok    = 1'b0;
      w_known = 1'b1;
      case (w_cmd)
        CMD_ACT:                    w_ok = w_act_ok;
        CMD_RD:                     w_ok = w_rd_ok;
        CMD_WR:                     w_ok = w_wr_ok;
        CMD_PRE, CMD_PREA, CMD_REF: w_ok = 1'b1;
        default:                    w_known = 1'b0;
      endcase
    end

    assign w_live[gi]     = req_i[gi] & w_known;
    assign w_prio_req[gi] = req_i[gi] & w_ok & is_prio_cmd(w_cmd);
    assign w_norm_req[gi] = req_i[gi] & w_ok & ~is_prio_cmd(w_cmd);
  end

  rr_arbiter #(.N(NUM_BANKS), .PW(BANK_W)) u_rr_prio (
    .req_i   (w_prio_req),
    .ptr_i   (r_rr_ptr),
    .grant_o (w_prio_gnt)
  );

  rr_arbiter #(.N(NUM_BANKS), .PW(BANK_W)) u_rr_norm (
    .req_i   (w_norm_req),
    .ptr_i   (r_rr_ptr),
    .grant_o (w_norm_gnt)
  );

  assign w_grant   = (rst_n && cmd_ready_i) ? ((|w_prio_req) ? w_prio_gnt : w_norm_gnt) : '0;
  assign w_any_gnt = |w_grant;
  assign grant_o   = w_grant;
  assign stall_o   = rst_n ? (w_live & ~w_grant) : '0;

  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_cmd  = CMD_NOP;
    w_gnt_addr = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx  = BANK_W'(i);
        w_gnt_cmd  = arb_cmd_t'(req_cmd_i[i]);
        w_gnt_addr = req_addr_i[i];
      end
    end
  end

  assign w_ptr_next = (int'(w_gnt_idx) == NUM_BANKS - 1) ? '0 : (w_gnt_idx + BANK_W'(1));

  // Spacing counters run regardless of cmd_ready_i; a grant reloads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrd_cnt <= '0;
      r_ccd_cnt <= '0;
      r_wtr_cnt <= '0;
    end else begin
      if (w_any_gnt && (w_gnt_cmd == CMD_ACT))
        r_rrd_cnt <= RRD_LOAD;
      else if (r_rrd_cnt != '0)
        r_rrd_cnt <= r_rrd_cnt - CNT_ONE;

      if (w_any_gnt && ((w_gnt_cmd == CMD_RD) || (w_gnt_cmd == CMD_WR)))
        r_ccd_cnt <= CCD_LOAD;
      else if (r_ccd_cnt != '0)
        r_ccd_cnt <= r_ccd_cnt - CNT_ONE;

      if (w_any_gnt && (w_gnt_cmd == CMD_WR))
        r_wtr_cnt <= WTR_LOAD;
      else if (r_wtr_cnt != '0)
        r_wtr_cnt <= r_wtr_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_NOP;
      r_cmd_bank  <= '0;
      r_cmd_addr  <= '0;
    end else if (w_any_gnt) begin
      r_rr_ptr    <= w_ptr_next;
      r_cmd_valid <= 1'b1;
      r_cmd_type  <= w_gnt_cmd;
      r_cmd_bank  <= w_gnt_idx;
      r_cmd_addr  <= w_gnt_addr;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= CMD_NOP;
    end
  end

  assign cmd_valid_o = r_cmd_valid;
  assign cmd_type_o  = r_cmd_type;
  assign cmd_bank_o  = r_cmd_bank;
  assign cmd_addr_o  = r_cmd_addr;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: directed timing scenarios plus random traffic
// checked against a timestamp-based model of the issue rules.
module tb_bank_cmd_arbiter;
  import bank_cmd_arbiter_pkg::*;

  localparam int NB   = 8;
  localparam int AW   = ADDR_BITS;
  localparam int TRRD = 4;
  localparam int TCCD = 4;
  localparam int TWTR = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NB-1:0]          req;
  logic [NB-1:0][2:0]     req_cmd;
  logic [NB-1:0][AW-1:0]  req_addr;
  logic                   cmd_ready;
  logic [NB-1:0]          grant;
  logic [NB-1:0]          stall;
  logic                   cmd_valid;
  logic [2:0]             cmd_type;
  logic [2:0]             cmd_bank;
  logic [AW-1:0]          cmd_addr;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: issue times, not counters
  int m_ptr;
  int m_cyc;
  int m_last_act;
  int m_last_cas;
  int m_last_wr;

  bank_cmd_arbiter #(
    .NUM_BANKS (NB),
    .T_RRD     (TRRD),
    .T_CCD     (TCCD),
    .T_WTR     (TWTR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_cmd_i   (req_cmd),
    .req_addr_i  (req_addr),
    .cmd_ready_i (cmd_ready),
    .grant_o     (grant),
    .stall_o     (stall),
    .cmd_valid_o (cmd_valid),
    .cmd_type_o  (cmd_type),
    .cmd_bank_o  (cmd_bank),
    .cmd_addr_o  (cmd_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_cmd   = '0;
    req_addr  = '0;
    cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int b, input arb_cmd_t c, input logic [AW-1:0] a);
    req[b]      = 1'b1;
    req_cmd[b]  = c;
    req_addr[b] = a;
  endtask

  function automatic bit model_elig(input int b);
    case (arb_cmd_t'(req_cmd[b]))
      CMD_ACT:                    return (m_cyc - m_last_act) >= TRRD;
      CMD_RD:                     return ((m_cyc - m_last_cas) >= TCCD) && ((m_cyc - m_last_wr) >= TWTR);
      CMD_WR:                     return (m_cyc - m_last_cas) >= TCCD;
      CMD_PRE, CMD_PREA, CMD_REF: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic int model_pick();
    arb_cmd_t c;
    int b;
    if (!cmd_ready) return -1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NB; k++) begin
        b = (m_ptr + k) % NB;
        c = arb_cmd_t'(req_cmd[b]);
        if (req[b] && model_elig(b) &&
            (((c == CMD_REF) || (c == CMD_PREA)) == (pass == 0)))
          return b;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = '1;
    req_cmd   = {NB{3'(CMD_PRE)}};
    req_addr  = '1;
    cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (grant !== 8'h00) begin n_err++; $display("FAIL reset_grant got=%b exp=%b", grant, 8'h00); end
    n_cmp++; if (stall !== 8'h00) begin n_err++; $display("FAIL reset_stall got=%b exp=%b", stall, 8'h00); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    n_cmp++; if (cmd_type !== 3'(CMD_NOP)) begin n_err++; $display("FAIL reset_type got=%0d exp=%0d", cmd_type, CMD_NOP); end
    n_cmp++; if (cmd_bank !== 3'd0) begin n_err++; $display("FAIL reset_bank got=%0d exp=0", cmd_bank); end
    n_cmp++; if (cmd_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", cmd_addr); end
    req = '0;
    rst_n = 1'b1;
    $display("reset: outputs checked while held in reset");
  endtask

  task automatic test_act_spacing();
    int waited;
    bit got;
    do_reset();
    set_req(0, CMD_ACT, 16'h0100);
    set_req(3, CMD_ACT, 16'h0300);
    @(negedge clk);
    n_cmp++; if (grant !== 8'h01) begin n_err++; $display("FAIL act_first_grant got=%b exp=%b", grant, 8'h01); end
    n_cmp++; if (stall !== 8'h08) begin n_err++; $display("FAIL act_first_stall got=%b exp=%b", stall, 8'h08); end
    tick();
    req[0] = 1'b0;
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_type !== 3'(CMD_ACT) || cmd_bank !== 3'd0 || cmd_addr !== 16'h0100) begin
      n_err++;
      $display("FAIL act_first_cmd got=v%b t%0d b%0d a%h exp=v1 t%0d b0 a0100", cmd_valid, cmd_type, cmd_bank, cmd_addr, CMD_ACT);
    end
    waited = 1;
    got    = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (grant === 8'h08) got = 1'b1;
      else begin
        n_cmp++; if (stall[3] !== 1'b1) begin n_err++; $display("FAIL act_wait_stall got=%b exp=1 wait=%0d", stall[3], waited); end
      end
      tick();
      if (!got) waited++;
    end
    req[3] = 1'b0;
    n_cmp++; if (waited != TRRD) begin n_err++; $display("FAIL act_rrd_gap got=%0d exp=%0d", waited, TRRD); end
    n_cmp++; if (cmd_valid !== 1'b1 || cmd_bank !== 3'd3 || cmd_addr !== 16'h0300) begin n_err++; $display("FAIL act_second_cmd got=v%b b%0d a%h exp=v1 b3 a0300", cmd_valid, cmd_bank, cmd_addr); end
    $display("act spacing: bank3 ACT issued %0d cycles after bank0", waited);
  endtask

  task automatic test_wtr();
    int waited;
    bit got;
    do_reset();
    set_req(2, CMD_WR, 16'h2222);
    @(negedge clk);
    n_cmp++; if (grant !== 8'h04) begin n_err++; $display("FAIL wtr_wr_grant got=%b exp=%b", grant, 8'h04); end
    tick();
    req[2] = 1'b0;
    set_req(5, CMD_RD, 16'h5555);
    waited = 1;
    got    = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      if (grant === 8'h20) got = 1'b1;
      else begin
        n_cmp++; if (stall[5] !== 1'b1) begin n_err++; $display("FAIL wtr_wait_stall got=%b exp=1 wait=%0d", stall[5], waited); end
      end
      tick();
      if (!got) waited++;
    end
    req[5] = 1'b0;
    n_cmp++; if (waited != TWTR) begin n_err++; $display("FAIL wtr_gap got=%0d exp=%0d", waited, TWTR); end
    n_cmp++; if (cmd_type !== 3'(CMD_RD) || cmd_bank !== 3'd5) begin n_err++; $display("FAIL wtr_rd_cmd got=t%0d b%0d exp=t%0d b5", cmd_type, cmd_bank, CMD_RD); end
    $display("wtr: bank5 RD issued %0d cycles after bank2 WR", waited);
  endtask

  task automatic test_priority();
    do_reset();
    set_req(0, CMD_PRE, 16'h0000);
    @(negedge clk);
    n_cmp++; if (grant !== 8'h01) begin n_err++; $display("FAIL prio_setup_grant got=%b exp=%b", grant, 8'h01); end
    tick();
    req[0] = 1'b0;
    set_req(1, CMD_RD, 16'h0111);
    set_req(6, CMD_REF, 16'h0666);
    @(negedge clk);
    n_cmp++; if (grant !== 8'h40) begin n_err++; $display("FAIL prio_ref_grant got=%b exp=%b", grant, 8'h40); end
    n_cmp++; if (stall !== 8'h02) begin n_err++; $display("FAIL prio_rd_stall got=%b exp=%b", stall, 8'h02); end
    tick();
    req[6] = 1'b0;
    n_cmp++; if (cmd_type !== 3'(CMD_REF) || cmd_bank !== 3'd6) begin n_err++; $display("FAIL prio_ref_cmd got=t%0d b%0d exp=t%0d b6", cmd_type, cmd_bank, CMD_REF); end
    @(negedge clk);
    n_cmp++; if (grant !== 8'h02) begin n_err++; $display("FAIL prio_rd_grant got=%b exp=%b", grant, 8'h02); end
    tick();
    req[1] = 1'b0;
    n_cmp++; if (cmd_type !== 3'(CMD_RD) || cmd_bank !== 3'd1) begin n_err++; $display("FAIL prio_rd_cmd got=t%0d b%0d exp=t%0d b1", cmd_type, cmd_bank, CMD_RD); end
    $display("priority: REF on bank6 issued ahead of RD on bank1");
  endtask

  task automatic test_all_pre();
    int pulses;
    logic [NB-1:0] e_gnt;
    do_reset();
    pulses = 0;
    for (int b = 0; b < NB; b++) set_req(b, CMD_PRE, AW'(b * 16));
    for (int k = 0; k < NB; k++) begin
      e_gnt = '0;
      e_gnt[k] = 1'b1;
      @(negedge clk);
      n_cmp++; if (grant !== e_gnt) begin n_err++; $display("FAIL allpre_grant k=%0d got=%b exp=%b", k, grant, e_gnt); end
      tick();
      req[k] = 1'b0;
      if (cmd_valid === 1'b1) pulses++;
      n_cmp++; if (cmd_bank !== 3'(k)) begin n_err++; $display("FAIL allpre_bank got=%0d exp=%0d", cmd_bank, k); end
    end
    tick();
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL allpre_idle_valid got=%b exp=0", cmd_valid); end
    n_cmp++; if (pulses != NB) begin n_err++; $display("FAIL allpre_pulses got=%0d exp=%0d", pulses, NB); end
    $display("all PRE: %0d consecutive command pulses", pulses);
  endtask

  task automatic test_ready_gap();
    do_reset();
    cmd_ready = 1'b0;
    set_req(4, CMD_ACT, 16'h4444);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 8'h00) begin n_err++; $display("FAIL rdy_grant k=%0d got=%b exp=%b", k, grant, 8'h00); end
      n_cmp++; if (stall !== 8'h10) begin n_err++; $display("FAIL rdy_stall k=%0d got=%b exp=%b", k, stall, 8'h10); end
      tick();
      n_cmp++; if (cmd_valid !== 1'b0 || cmd_type !== 3'(CMD_NOP)) begin n_err++; $display("FAIL rdy_idle_cmd got=v%b t%0d exp=v0 t0", cmd_valid, cmd_type); end
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (grant !== 8'h10) begin n_err++; $display("FAIL rdy_release_grant got=%b exp=%b", grant, 8'h10); end
    tick();
    req[4] = 1'b0;
    n_cmp++; if (cmd_valid !== 1'b1 || cmd_bank !== 3'd4 || cmd_addr !== 16'h4444) begin n_err++; $display("FAIL rdy_release_cmd got=v%b b%0d a%h exp=v1 b4 a4444", cmd_valid, cmd_bank, cmd_addr); end
    $display("ready gap: bank4 ACT issued on first ready cycle");
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, CMD_ACT, 16'h0abc);
    @(negedge clk);
    n_cmp++; if (grant !== 8'h04) begin n_err++; $display("FAIL rmid_grant got=%b exp=%b", grant, 8'h04); end
    tick();
    req[2] = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", cmd_valid); end
    n_cmp++; if (cmd_type !== 3'(CMD_NOP) || cmd_bank !== 3'd0 || cmd_addr !== '0) begin n_err++; $display("FAIL rmid_cmd got=t%0d b%0d a%h exp=t0 b0 a0", cmd_type, cmd_bank, cmd_addr); end
    tick();
    rst_n = 1'b1;
    set_req(1, CMD_ACT, 16'h0111);
    set_req(5, CMD_ACT, 16'h0555);
    @(negedge clk);
    n_cmp++; if (grant !== 8'h02) begin n_err++; $display("FAIL rmid_after_grant got=%b exp=%b", grant, 8'h02); end
    tick();
    req = '0;
    $display("reset mid-operation: pending command discarded, pointer and counters cleared");
  endtask

  task automatic test_random();
    int g;
    int r;
    logic [NB-1:0] e_gnt;
    logic [NB-1:0] e_stall;
    logic          e_valid;
    logic [2:0]    e_type;
    logic [2:0]    e_bank;
    logic [AW-1:0] e_addr;
    do_reset();
    m_ptr      = 0;
    m_cyc      = 0;
    m_last_act = -1000;
    m_last_cas = -1000;
    m_last_wr  = -1000;
    e_bank     = '0;
    e_addr     = '0;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < NB; b++) begin
        if (!req[b] && ($urandom_range(0, 99) < 35)) begin
          r = $urandom_range(0, 19);
          req[b]      = 1'b1;
          req_addr[b] = AW'($urandom);
          if (r == 0)       req_cmd[b] = CMD_NOP;
          else if (r <= 5)  req_cmd[b] = CMD_ACT;
          else if (r <= 9)  req_cmd[b] = CMD_RD;
          else if (r <= 13) req_cmd[b] = CMD_WR;
          else if (r <= 16) req_cmd[b] = CMD_PRE;
          else if (r == 17) req_cmd[b] = CMD_PREA;
          else              req_cmd[b] = CMD_REF;
        end
      end
      cmd_ready = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      g = model_pick();
      e_gnt = '0;
      if (g >= 0) e_gnt[g] = 1'b1;
      for (int b = 0; b < NB; b++)
        e_stall[b] = req[b] && (req_cmd[b] != 3'(CMD_NOP)) && (g != b);
      n_cmp++; if (grant !== e_gnt) begin n_err++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", m_cyc, grant, e_gnt); end
      n_cmp++; if (stall !== e_stall) begin n_err++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", m_cyc, stall, e_stall); end
      if (g >= 0) begin
        e_valid = 1'b1;
        e_type  = req_cmd[g];
        e_bank  = 3'(g);
        e_addr  = req_addr[g];
        if (req_cmd[g] == 3'(CMD_ACT)) m_last_act = m_cyc;
        if (req_cmd[g] == 3'(CMD_RD) || req_cmd[g] == 3'(CMD_WR)) m_last_cas = m_cyc;
        if (req_cmd[g] == 3'(CMD_WR)) m_last_wr = m_cyc;
        m_ptr = (g + 1) % NB;
      end else begin
        e_valid = 1'b0;
        e_type  = 3'(CMD_NOP);
      end
      tick();
      m_cyc++;
      n_cmp++; if (cmd_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", m_cyc, cmd_valid, e_valid); end
      n_cmp++; if (cmd_type !== e_type) begin n_err++; $display("FAIL rnd_type cyc=%0d got=%0d exp=%0d", m_cyc, cmd_type, e_type); end
      n_cmp++; if (cmd_bank !== e_bank) begin n_err++; $display("FAIL rnd_bank cyc=%0d got=%0d exp=%0d", m_cyc, cmd_bank, e_bank); end
      n_cmp++; if (cmd_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", m_cyc, cmd_addr, e_addr); end
      if (g >= 0) begin
        $display("rnd cyc=%0d bank=%0d cmd=%0d addr=%h", m_cyc, g, e_type, e_addr);
        req[g] = 1'b0;
      end
      for (int b = 0; b < NB; b++)
        if (req_cmd[b] == 3'(CMD_NOP)) req[b] = 1'b0;
    end
    req = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_cmd   = '0;
    req_addr  = '0;
    cmd_ready = 1'b1;
    test_reset();
    test_act_spacing();
    test_wtr();
    test_priority();
    test_all_pre();
    test_ready_gap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
